// File: rtl/ssd_pkg.sv
// Shared types, constants and the anode helper for the seven-segment scan driver.
package ssd_pkg;

  localparam int SSD_DIGITS = 4;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  typedef logic [3:0] ssd_digit_t;
  typedef logic [1:0] ssd_sel_t;

  function automatic logic [3:0] ssd_anode_onehot(input ssd_sel_t sel);
    return ~(4'b0001 << sel);
  endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// Digit dwell prescaler: counts 0..DIV-1, flags the last count and the dead-time
// window at the start of each digit slot (judged on the next count value).
module ssd_prescaler #(
  parameter int DIV       = 10,
  parameter int GUARD_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o,
  output logic guard_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick_o  = (cnt_q == LAST);
    cnt_d   = tick_o ? '0 : cnt_q + 1'b1;
    guard_o = (cnt_d < GUARD_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit seven-segment scan driver with frame-aligned double buffering.
// Optional leading-zero blanking is built when SSD_LEAD_ZERO_BLANK_EN is defined.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic        blank_en,
  output logic [1:0]  scan_sel,
  output logic [3:0]  digit_val,
  output logic [3:0]  anodes_n,
  output logic        digit_blank,
  output logic        frame_done
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int BUF_W = 4 * SSD_DIGITS;

  if (DIV < GUARD_CYC + 2) begin : g_bad_div
    $error("ssd_scan_driver: CLK_HZ/SCAN_HZ must be at least GUARD_CYC+2");
  end

  logic tick;
  logic guard;
  logic boundary;
  logic transfer;

  ssd_sel_t         sel_q, sel_d;
  logic [BUF_W-1:0] active_q, active_d;
  logic [BUF_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             wr_ready_q;
  ssd_digit_t       digit_val_q, digit_val_d;
  logic [3:0]       anodes_q, anodes_d;
  logic             digit_blank_q, digit_blank_d;
  logic             frame_done_q;

  ssd_prescaler #(
    .DIV       (DIV),
    .GUARD_CYC (GUARD_CYC)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_o  (tick),
    .guard_o (guard)
  );

`ifdef SSD_LEAD_ZERO_BLANK_EN
  function automatic logic lead_zero(input logic [BUF_W-1:0] v, input ssd_sel_t s);
    case (s)
      2'd1:    return (v[15:4] == '0);
      2'd2:    return (v[15:8] == '0);
      2'd3:    return (v[15:12] == '0);
      default: return 1'b0;
    endcase
  endfunction
`endif

  // A commit and a transfer are mutually exclusive because they need opposite
  // pending states, so a write landing on a boundary only fills the shadow.
  always_comb begin
    boundary  = tick && (sel_q == 2'd3);
    transfer  = wr_valid && !pending_q;
    sel_d     = tick ? sel_q + 2'd1 : sel_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (transfer) begin
      shadow_d  = wr_data;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    digit_val_d = active_d[{sel_d, 2'b00} +: 4];
`ifdef SSD_LEAD_ZERO_BLANK_EN
    digit_blank_d = blank_en || lead_zero(active_d, sel_d);
`else
    digit_blank_d = blank_en;
`endif
    anodes_d = (guard || blank_en || digit_blank_d) ? ANODES_OFF : ssd_anode_onehot(sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q         <= '0;
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      wr_ready_q    <= 1'b1;
      digit_val_q   <= '0;
      anodes_q      <= ANODES_OFF;
      digit_blank_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      wr_ready_q    <= !pending_d;
      digit_val_q   <= digit_val_d;
      anodes_q      <= anodes_d;
      digit_blank_q <= digit_blank_d;
      frame_done_q  <= boundary;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign scan_sel    = sel_q;
  assign digit_val   = digit_val_q;
  assign anodes_n    = anodes_q;
  assign digit_blank = digit_blank_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver; the reference derives every output from the
// cycle count since reset and a frame-level model of the write/commit rules.
module tb_ssd_scan_driver;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int GUARD   = 2;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrValid;
  logic [15:0] wrData;
  logic        blankEn;
  logic        wrReady;
  logic [1:0]  scanSel;
  logic [3:0]  digitVal;
  logic [3:0]  anodesN;
  logic        digitBlank;
  logic        frameDone;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] val;
    logic [3:0] an;
    logic       blank;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [15:0] shadowVal;
  logic [15:0] activeVal;
  bit          hasPending;

  ssd_scan_driver #(
    .CLK_HZ    (CLK_HZ),
    .SCAN_HZ   (SCAN_HZ),
    .GUARD_CYC (GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wrValid),
    .wr_ready    (wrReady),
    .wr_data     (wrData),
    .blank_en    (blankEn),
    .scan_sel    (scanSel),
    .digit_val   (digitVal),
    .anodes_n    (anodesN),
    .digit_blank (digitBlank),
    .frame_done  (frameDone)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    cyc        = 0;
    shadowVal  = 16'h0000;
    activeVal  = 16'h0000;
    hasPending = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    cmp({tag, "_scan_sel"}, scanSel, 0);
    cmp({tag, "_digit_val"}, digitVal, 0);
    cmp({tag, "_anodes_n"}, anodesN, 'hF);
    cmp({tag, "_digit_blank"}, digitBlank, 0);
    cmp({tag, "_frame_done"}, frameDone, 0);
    cmp({tag, "_wr_ready"}, wrReady, 1);
  endtask

  // Drive inputs for the next rising edge and queue what the outputs must be after it.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic b);
    exp_t e;
    int   pos;
    int   sel;
    int   upper;
    @(negedge clk);
    wrValid = v;
    wrData  = d;
    blankEn = b;
    cyc++;
    if ((cyc % FRAME == 0) && hasPending) begin
      activeVal  = shadowVal;
      hasPending = 1'b0;
    end else if (v && !hasPending) begin
      shadowVal  = d;
      hasPending = 1'b1;
    end
    pos     = cyc % DIV;
    sel     = (cyc / DIV) % 4;
    upper   = int'(activeVal) >> (4 * sel);
    e.sel   = sel[1:0];
    e.val   = 4'(upper & 'hF);
    e.blank = b;
`ifdef SSD_LEAD_ZERO_BLANK_EN
    if (sel > 0 && upper == 0) e.blank = 1'b1;
`endif
    e.an  = (pos < GUARD || b || e.blank) ? 4'hF : 4'(15 - (1 << sel));
    e.fd  = (cyc % FRAME == 0);
    e.rdy = !hasPending;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("scan_sel", scanSel, e.sel);
    cmp("digit_val", digitVal, e.val);
    cmp("anodes_n", anodesN, e.an);
    cmp("digit_blank", digitBlank, e.blank);
    cmp("frame_done", frameDone, e.fd);
    cmp("wr_ready", wrReady, e.rdy);
  endtask

  // Monitor: compare one queued expectation shortly after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rst_n   = 1'b0;
    wrValid = 1'b0;
    wrData  = 16'h0000;
    blankEn = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #3;
    checkResetValues("reset");
    rst_n = 1'b1;

    repeat (FRAME + 5) applyStimulus(1'b0, 16'h0000, 1'b0);

    while (cyc % FRAME != 12) applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h1234, 1'b0);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'hFFFF, 1'b0);

    while (cyc % FRAME != 5) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (20) applyStimulus(1'b1, 16'hABCD, 1'b0);
    repeat (50) applyStimulus(1'b1, 16'h5555, 1'b0);
    repeat (2 * FRAME) applyStimulus(1'b0, 16'h0000, 1'b0);

    while (cyc % FRAME != FRAME - 1) applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h0070, 1'b0);
    repeat (3 * FRAME) applyStimulus(1'b0, 16'h9999, 1'b0);

    while (cyc % FRAME != FRAME - 1) applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (FRAME) applyStimulus(1'b0, 16'h0000, 1'b1);

    while (cyc % FRAME != 2 * DIV + 5) applyStimulus(1'b1, 16'h4321, 1'b0);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    wrValid = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (FRAME + 3) applyStimulus(1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 800; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
      applyStimulus($urandom_range(0, 3) == 0, d, $urandom_range(0, 15) == 0);
    end

    @(posedge clk);
    #3;
    cmp("queue_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Drives the scan side of the four-digit seven-segment display interface. It generates the 2-bit digit-scan select at a programmable refresh rate and presents the nibble for the selected digit. It also drives the active-low anodes with anti-ghosting dead time. It accepts new 16-bit display values over a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between system logic and the hex-to-cathode decoder.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz.
SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ cycles per digit.
GUARD_CYC, 16, cycles at the start of each digit slot with all anodes off. Elaboration error unless DIV >= GUARD_CYC+2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  new display value offered
wr_ready  out  1  driver can accept a value
wr_data  in  16  digits {d3,d2,d1,d0}; d3 is most significant
blank_en  in  1  global blank; forces all anodes off
scan_sel  out  2  currently scanned digit index
digit_val  out  4  nibble of the active buffer for scan_sel
anodes_n  out  4  active-low one-hot anode enables (bit i = digit i)
digit_blank  out  1  current digit is blanked
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n, with a synchronous deassertion assumption on the clock edge. All outputs are registered.
- Reset values:
  - prescaler 0, scan_sel 0, active buffer 16'h0000, shadow 0, pending 0.
  - wr_ready 1, anodes_n 4'hF, digit_val 0, digit_blank 0, frame_done 0.
- Prescaler counts 0..DIV-1 and wraps to 0. tick is asserted when prescaler == DIV-1.
- On tick, scan_sel increments and wraps 3 -> 0.
- Frame boundary = tick while scan_sel == 3. frame_done pulses high on the cycle after the boundary edge, i.e. registered together with scan_sel returning to 0.
- Handshake:
  - wr_ready = !pending. A transfer occurs when wr_valid && wr_ready.
  - On transfer: shadow <= wr_data and pending <= 1.
  - wr_data is sampled only on a transfer. wr_valid may drop without a transfer.
- Commit: at a frame boundary with pending == 1, active <= shadow and pending <= 0. wr_ready returns high on the following cycle.
- Simultaneous transfer and boundary (pending == 0): the data goes to shadow only. It commits at the next boundary, not the current one.
- Output timing:
  - digit_val = active[4*scan_sel +: 4], computed from next-state values.
  - scan_sel, digit_val and anodes_n change on the same edge.
  - A commit becomes visible on digit 0 of the new frame.
- anodes_n:
  - 4'hF when next prescaler < GUARD_CYC, or blank_en, or digit_blank.
  - Otherwise ~(4'b0001 << scan_sel).
  - Exactly zero or one bit is low at any time.
- digit_blank = blank_en when the optional feature is absent.
- blank_en takes effect on the next edge. It does not affect the handshake, commit, or scan counting.
- Reset asserted mid-frame or mid-handshake discards shadow and pending asynchronously and returns all state to reset values.

Optional Feature:
- Macro: SSD_LEAD_ZERO_BLANK_EN.
- Defined: digit i (i = 1..3) is blanked when its nibble is 0 and every more significant nibble of the active buffer is also 0. Blanked digits set digit_blank = 1 and anodes_n = 4'hF. Digit 0 is never lead-blanked.
- Undefined: no leading-zero logic is built; digit_blank = blank_en.

Decomposition:
- Package ssd_pkg:
  - SSD_DIGITS = 4 constant.
  - typedef logic [3:0] ssd_digit_t.
  - typedef logic [1:0] ssd_sel_t.
  - ANODES_OFF = 4'hF constant.
  - function ssd_anode_onehot(ssd_sel_t) returning the active-low one-hot anode vector.
- Sub-module ssd_prescaler (parameter DIV; outputs tick and a guard flag) instantiated once. The buffer, handshake and anode logic stay in ssd_scan_driver.

Test Plan:
1. Bench parameters CLK_HZ=1000, SCAN_HZ=100 (DIV=10), GUARD_CYC=2. Release reset -> anodes_n=4'hF for 2 cycles, then 4'hE for 8 cycles. scan_sel steps 0,1,2,3,0 every 10 cycles. frame_done pulses every 40 cycles.
2. Write 16'h1234 mid-frame -> wr_ready low the next cycle. digit_val holds 0 until the frame boundary, then reads 4,3,2,1 for sel 0..3. wr_ready is high again the cycle after commit.
3. Hold wr_valid with 16'hABCD while pending, then change the data to 16'h5555 before ready returns -> 16'hABCD is committed. 16'h5555 transfers when wr_ready rises and commits one frame later.
4. wr_valid coinciding with the boundary edge with pending=0 -> the value is not shown in the immediately following frame, and is shown in the next one.
5. blank_en=1 for one full frame -> anodes_n=4'hF throughout while scan_sel and frame_done continue. Assert rst_n=0 at prescaler=5, sel=2 -> all outputs return to reset values immediately.
6. SSD_LEAD_ZERO_BLANK_EN defined, active=16'h0070 -> digits 3 and 2 blanked (digit_blank=1, anodes_n=4'hF), digits 1 and 0 lit. active=16'h0000 -> only digit 0 lit.
